// File: rtl/store_capture_fifo.sv
// Observes the CPU data-memory store bus, queues stores that land in an address window,
// drains them over a valid/ready handshake and latches a sticky pass/fail signature verdict.
module store_capture_fifo #(
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3,
  parameter logic [31:0] WIN_LO    = 32'h0,
  parameter logic [31:0] WIN_HI    = 32'hFF,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'hFFFF7F02
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic          pass,
  output logic          fail
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   win_offset;
  logic          in_window;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          sig_hit;

  // Offset compare covers LO<=adr<=HI in one unsigned test: addresses below LO wrap to huge values.
  assign win_offset = dataadr - WIN_LO;
  assign in_window  = (win_offset <= (WIN_HI - WIN_LO));

  assign out_valid = (count != '0);
  assign full      = (count == FULL_COUNT);
  assign push      = memwrite && in_window;
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign out_addr  = mem[rd_ptr][63:32];
  assign out_data  = mem[rd_ptr][31:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {dataadr, writedata};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign sig_hit = memwrite && (dataadr == PASS_ADDR);

  // Whichever verdict arrives first locks out the other.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      if (sig_hit && (writedata == PASS_DATA) && !fail) pass <= 1'b1;
      if (sig_hit && (writedata != PASS_DATA) && !pass) fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_store_capture_fifo.sv
// Directed bench for store_capture_fifo: reset, capture, overflow, full push+pop, window and verdict.
module tb_store_capture_fifo;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        full;
  logic        overflow;
  logic        pass;
  logic        fail;

  int total;
  int bad;

  store_capture_fifo dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count), .full(full),
    .overflow(overflow), .pass(pass), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of bus inputs, then returns 1ns after the edge so outputs can be sampled.
  task automatic apply_stimulus(input logic rst_n, input logic mw, input logic [31:0] adr,
                                input logic [31:0] dat, input logic rdy);
    reset     = rst_n;
    memwrite  = mw;
    dataadr   = adr;
    writedata = dat;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b1, 32'd84, 32'hFFFF7F02, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'd8, 32'd1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; out_ready = 1'b0;

    // Reset held two cycles with stores active
    apply_stimulus(1'b0, 1'b1, 32'd84, 32'hFFFF7F02, 1'b0);
    apply_stimulus(1'b0, 1'b1, 32'd8, 32'd1, 1'b1);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_flags", {61'd0, pass, fail, overflow}, 64'd0);
    check_output("rst_head", {out_addr, out_data}, 64'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    // Single store, held at head while not ready, then popped
    apply_stimulus(1'b1, 1'b1, 32'd80, 32'd7, 1'b0);
    check_output("single_valid", 64'(out_valid), 64'd1);
    check_output("single_head", {out_addr, out_data}, {32'd80, 32'd7});
    check_output("single_count", 64'(count), 64'd1);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    check_output("single_hold", {out_addr, out_data}, {32'd80, 32'd7});
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check_output("single_popped", 64'(count), 64'd0);
    check_output("single_empty", 64'(out_valid), 64'd0);

    // Empty + push + ready: no pop that cycle
    apply_stimulus(1'b1, 1'b1, 32'd12, 32'd3, 1'b1);
    check_output("empty_push_rdy_count", 64'(count), 64'd1);
    check_output("empty_push_rdy_head", 64'(out_addr), 64'd12);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check_output("empty_push_rdy_drain", 64'(count), 64'd0);

    // Fill with 9 stores; the ninth is dropped
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 1'b1, 32'(i * 4), 32'(100 + i), 1'b0);
      if (i == 7) begin
        check_output("fill8_full", 64'(full), 64'd1);
        check_output("fill8_ovf", 64'(overflow), 64'd0);
      end
    end
    check_output("fill9_count", 64'(count), 64'd8);
    check_output("fill9_full", 64'(full), 64'd1);
    check_output("fill9_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("drain_%0d", i), {out_addr, out_data}, {32'(i * 4), 32'(100 + i)});
      apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    check_output("drain_count", 64'(count), 64'd0);
    check_output("drain_ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, 32'(i * 4), 32'(200 + i), 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'd40, 32'd77, 1'b1);
    check_output("fullpp_count", 64'(count), 64'd8);
    check_output("fullpp_ovf", 64'(overflow), 64'd0);
    check_output("fullpp_head", 64'(out_addr), 64'd4);
    for (int i = 1; i < 8; i++) begin
      check_output($sformatf("fullpp_drain_%0d", i), {out_addr, out_data}, {32'(i * 4), 32'(200 + i)});
      apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    check_output("fullpp_last", {out_addr, out_data}, {32'd40, 32'd77});
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    check_output("fullpp_empty", 64'(count), 64'd0);

    // Window edges
    apply_stimulus(1'b1, 1'b1, 32'h100, 32'd9, 1'b0);
    check_output("win_out", 64'(count), 64'd0);
    apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd9, 1'b0);
    check_output("win_wrap", 64'(count), 64'd0);
    apply_stimulus(1'b1, 1'b1, 32'hFF, 32'h55, 1'b0);
    check_output("win_edge_count", 64'(count), 64'd1);
    check_output("win_edge_head", {out_addr, out_data}, {32'hFF, 32'h55});
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'd0, 1'b1);

    // Verdict: pass first locks out fail
    do_reset();
    apply_stimulus(1'b0 | 1'b1, 1'b0, 32'd84, 32'hFFFF7F02, 1'b0);
    check_output("verdict_idle", {62'd0, pass, fail}, 64'd0);
    apply_stimulus(1'b1, 1'b1, 32'd84, 32'hFFFF7F02, 1'b0);
    check_output("verdict_pass", {62'd0, pass, fail}, 64'b10);
    apply_stimulus(1'b1, 1'b1, 32'd84, 32'd5, 1'b0);
    check_output("verdict_pass_lock", {62'd0, pass, fail}, 64'b10);

    // Verdict: fail first locks out pass
    do_reset();
    check_output("verdict_rst", {62'd0, pass, fail}, 64'd0);
    apply_stimulus(1'b1, 1'b1, 32'd84, 32'd5, 1'b0);
    check_output("verdict_fail", {62'd0, pass, fail}, 64'b01);
    apply_stimulus(1'b1, 1'b1, 32'd84, 32'hFFFF7F02, 1'b0);
    check_output("verdict_fail_lock", {62'd0, pass, fail}, 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
